// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALU opcodes, multiplier FSM states
// and the radix-4 Booth digit decode.
package ex_pkg;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_SLL   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_SLT   = 4'd8;
    localparam logic [3:0] ALU_SLTU  = 4'd9;
    localparam logic [3:0] ALU_BEQ   = 4'd10;
    localparam logic [3:0] ALU_BNE   = 4'd11;
    localparam logic [3:0] ALU_BLT   = 4'd12;
    localparam logic [3:0] ALU_BGE   = 4'd13;
    localparam logic [3:0] ALU_PASSB = 4'd14;

    localparam logic [1:0] MUL_IDLE = 2'd0;
    localparam logic [1:0] MUL_BUSY = 2'd1;
    localparam logic [1:0] MUL_DONE = 2'd2;

    localparam logic [2:0] BOOTH_ZERO = 3'd0;
    localparam logic [2:0] BOOTH_POS1 = 3'd1;
    localparam logic [2:0] BOOTH_POS2 = 3'd2;
    localparam logic [2:0] BOOTH_NEG1 = 3'd3;
    localparam logic [2:0] BOOTH_NEG2 = 3'd4;

    // Bits are {b[2i+1], b[2i], b[2i-1]}; the digit selects 0, +/-1 or +/-2 times the multiplicand.
    function automatic logic [2:0] booth_decode(input logic [2:0] bits);
        case (bits)
            3'b001, 3'b010: return BOOTH_POS1;
            3'b011:         return BOOTH_POS2;
            3'b100:         return BOOTH_NEG2;
            3'b101, 3'b110: return BOOTH_NEG1;
            default:        return BOOTH_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/ex_mul_radix4.sv
// Iterative radix-4 Booth multiplier producing the low XLEN bits of a*b.
// The first Booth digit is consumed on the accept cycle so the unit stalls for exactly XLEN/2 cycles.
module ex_mul_radix4
    import ex_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            hold,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] product
);
    localparam int CW = $clog2(XLEN / 2 + 1);

    logic [1:0]      r_state;
    logic [XLEN-1:0] r_acc;
    logic [XLEN-1:0] r_mcand;
    logic [XLEN-1:0] r_mplier;
    logic            r_prev;
    logic [CW-1:0]   r_count;

    logic [XLEN-1:0] w_mcand;
    logic [2:0]      w_bits;
    logic [XLEN-1:0] w_pp;

    // In IDLE the digit comes straight from the operands; afterwards from the shifted copies.
    always_comb begin
        w_mcand = (r_state == MUL_IDLE) ? a : r_mcand;
        w_bits  = (r_state == MUL_IDLE) ? {b[1:0], 1'b0} : {r_mplier[1:0], r_prev};
        case (booth_decode(w_bits))
            BOOTH_POS1: w_pp = w_mcand;
            BOOTH_POS2: w_pp = {w_mcand[XLEN-2:0], 1'b0};
            BOOTH_NEG1: w_pp = -w_mcand;
            BOOTH_NEG2: w_pp = -{w_mcand[XLEN-2:0], 1'b0};
            default:    w_pp = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= MUL_IDLE;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prev   <= 1'b0;
            r_count  <= '0;
        end else begin
            case (r_state)
                MUL_IDLE: begin
                    if (start) begin
                        r_acc    <= w_pp;
                        r_mcand  <= {a[XLEN-3:0], 2'b00};
                        r_mplier <= {2'b00, b[XLEN-1:2]};
                        r_prev   <= b[1];
                        r_count  <= CW'(XLEN / 2 - 1);
                        r_state  <= MUL_BUSY;
                    end
                end
                MUL_BUSY: begin
                    r_acc    <= r_acc + w_pp;
                    r_mcand  <= {r_mcand[XLEN-3:0], 2'b00};
                    r_mplier <= {2'b00, r_mplier[XLEN-1:2]};
                    r_prev   <= r_mplier[1];
                    r_count  <= r_count - 1'b1;
                    if (r_count == CW'(1)) r_state <= MUL_DONE;
                end
                MUL_DONE: begin
                    if (!hold) r_state <= MUL_IDLE;
                end
                default: r_state <= MUL_IDLE;
            endcase
        end
    end

    assign busy    = start & (r_state != MUL_DONE);
    assign done    = (r_state == MUL_DONE);
    assign product = r_acc;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: inline ALU, branch/jump resolution against the predictor, and the EX->MEM register.
// Multiplies go to ex_mul_radix4 and hold upstream stages until the product is ready.
module ex_stage
    import ex_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int PC_BITS = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [XLEN-1:0]    ex_a,
    input  logic [XLEN-1:0]    ex_b,
    input  logic [XLEN-1:0]    ex_a2,
    input  logic [XLEN-1:0]    ex_b2,
    input  logic [3:0]         ex_alu_op,
    input  logic [4:0]         ex_rd,
    input  logic               ex_ld,
    input  logic               ex_str,
    input  logic               ex_byt,
    input  logic               ex_we,
    input  logic               ex_brn,
    input  logic               ex_jmp,
    input  logic               ex_mul,
    input  logic               ex_link_we,
    input  logic [XLEN-1:0]    ex_link_addr,
    input  logic               ex_bp_taken,
    input  logic [PC_BITS-1:0] ex_bp_target_pc,
    input  logic               mem_stall,
    output logic               ex_taken,
    output logic [PC_BITS-1:0] ex_redirect_pc,
    output logic               mul_busy,
    output logic [XLEN-1:0]    m_result,
    output logic [XLEN-1:0]    m_store_data,
    output logic [4:0]         m_rd,
    output logic               m_ld,
    output logic               m_str,
    output logic               m_byt,
    output logic               m_we
);
    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0]     w_shamt;
    logic               w_lt_s;
    logic               w_lt_u;
    logic               w_eq;
    logic               w_cond;
    logic [XLEN-1:0]    w_alu_result;
    logic [XLEN-1:0]    w_product;
    logic [XLEN-1:0]    w_result;
    logic               w_mul_busy;
    logic               w_mul_done;
    logic               w_actual_taken;
    logic               w_mispredict;
    logic [PC_BITS-1:0] w_target;
    logic               w_unused_a2_hi;

    assign w_shamt = ex_b[SHW-1:0];
    assign w_lt_s  = $signed(ex_a) < $signed(ex_b);
    assign w_lt_u  = ex_a < ex_b;
    assign w_eq    = ex_a == ex_b;

    always_comb begin
        case (ex_alu_op)
            ALU_SLT, ALU_BLT: w_cond = w_lt_s;
            ALU_SLTU:         w_cond = w_lt_u;
            ALU_BEQ:          w_cond = w_eq;
            ALU_BNE:          w_cond = !w_eq;
            ALU_BGE:          w_cond = !w_lt_s;
            default:          w_cond = 1'b0;
        endcase
    end

    always_comb begin
        case (ex_alu_op)
            ALU_ADD:   w_alu_result = ex_a + ex_b;
            ALU_SUB:   w_alu_result = ex_a - ex_b;
            ALU_AND:   w_alu_result = ex_a & ex_b;
            ALU_OR:    w_alu_result = ex_a | ex_b;
            ALU_XOR:   w_alu_result = ex_a ^ ex_b;
            ALU_SLL:   w_alu_result = ex_a << w_shamt;
            ALU_SRL:   w_alu_result = ex_a >> w_shamt;
            ALU_SRA:   w_alu_result = $unsigned($signed(ex_a) >>> w_shamt);
            ALU_SLT, ALU_SLTU, ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE:
                       w_alu_result = {{(XLEN-1){1'b0}}, w_cond};
            ALU_PASSB: w_alu_result = ex_b;
            default:   w_alu_result = '0;
        endcase
    end

    ex_mul_radix4 #(.XLEN(XLEN)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (ex_mul),
        .hold    (mem_stall),
        .a       (ex_a),
        .b       (ex_b),
        .busy    (w_mul_busy),
        .done    (w_mul_done),
        .product (w_product)
    );

    assign mul_busy = w_mul_busy;

    // Only the low PC bits of the target operand name a fetch address.
    assign w_target       = ex_a2[PC_BITS-1:0];
    assign w_unused_a2_hi = ^ex_a2[XLEN-1:PC_BITS];
    assign w_actual_taken = ex_jmp | (ex_brn & w_cond);
    assign w_mispredict   = (ex_brn | ex_jmp) &
                            ((w_actual_taken != ex_bp_taken) |
                             (w_actual_taken & (w_target != ex_bp_target_pc)));
    assign ex_taken       = w_mispredict & !w_mul_busy;
    assign ex_redirect_pc = w_actual_taken ? w_target : ex_link_addr[PC_BITS-1:0];

    assign w_result = ex_link_we ? ex_link_addr :
                      (ex_mul ? (w_mul_done ? w_product : '0) : w_alu_result);

    // Stall holds everything; an in-flight multiply feeds bubbles until its DONE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_result     <= '0;
            m_store_data <= '0;
            m_rd         <= '0;
            m_ld         <= 1'b0;
            m_str        <= 1'b0;
            m_byt        <= 1'b0;
            m_we         <= 1'b0;
        end else if (!mem_stall) begin
            if (w_mul_busy) begin
                m_result     <= '0;
                m_store_data <= '0;
                m_rd         <= '0;
                m_ld         <= 1'b0;
                m_str        <= 1'b0;
                m_byt        <= 1'b0;
                m_we         <= 1'b0;
            end else begin
                m_result     <= w_result;
                m_store_data <= ex_b2;
                m_rd         <= ex_rd;
                m_ld         <= ex_ld;
                m_str        <= ex_str;
                m_byt        <= ex_byt;
                m_we         <= ex_we;
            end
        end
    end

endmodule
